// File: rtl/mac_accu_pkg.sv
// Shared constants, FSM encoding and saturation bounds for the MAC accumulation stage.
package mac_accu_pkg;

    localparam int MAC_W = 36;
    localparam int ACC_W = 44;
    localparam int OUT_W = 32;

    // Output clamp range; wide signed copies are used for comparisons on the rounded sum.
    localparam logic signed [63:0] SAT_MAX_WIDE = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] SAT_MIN_WIDE = -64'sh0000_0000_8000_0000;
    localparam logic [OUT_W-1:0]   SAT_MAX_OUT  = 32'h7FFF_FFFF;
    localparam logic [OUT_W-1:0]   SAT_MIN_OUT  = 32'h8000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } accu_state_e;

endpackage

// File: rtl/mac_accu_if.sv
// Beat input from the MAC plus the result valid/ready stream.
interface mac_accu_if;
    import mac_accu_pkg::*;

    logic signed [MAC_W-1:0] mac_out_data;
    logic                    mac_out_pvld;
    logic [OUT_W-1:0]        accu_out_data;
    logic                    accu_out_pvld;
    logic                    accu_out_prdy;

    // Accumulator side: consumes beats, produces results.
    modport master (
        input  mac_out_data,
        input  mac_out_pvld,
        input  accu_out_prdy,
        output accu_out_data,
        output accu_out_pvld
    );

    // Environment side: drives beats, accepts results.
    modport slave (
        output mac_out_data,
        output mac_out_pvld,
        output accu_out_prdy,
        input  accu_out_data,
        input  accu_out_pvld
    );

endinterface

// File: rtl/mac_accu_fifo.sv
// Small synchronous FIFO; a write into a full FIFO succeeds only when a read frees a slot the same cycle.
module mac_accu_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer and storage update; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mac_accu.sv
// Accumulates a configured number of MAC beats per point, rounds/shifts, saturates to 32 bits
// and queues the result in an output FIFO. The MAC cannot be stalled, so a full FIFO drops
// results and raises a sticky overflow flag.
module mac_accu #(
    parameter int FIFO_DEPTH = 4,
    parameter int ACC_W      = mac_accu_pkg::ACC_W
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              cfg_reg_en,
    input  logic [7:0]        cfg_accu_len,
    input  logic [4:0]        cfg_trunc,
    mac_accu_if.master        accu_bus,
    output logic              accu_ovf,
    output logic [15:0]       accu_sat_cnt
);
    import mac_accu_pkg::*;

    localparam logic signed [ACC_W:0] SAT_MAX_R = (ACC_W+1)'(SAT_MAX_WIDE);
    localparam logic signed [ACC_W:0] SAT_MIN_R = (ACC_W+1)'(SAT_MIN_WIDE);

    accu_state_e             state;
    logic [7:0]              len_q;
    logic [4:0]              trunc_q;
    logic [7:0]              beat_cnt;
    logic signed [ACC_W-1:0] partial;
    logic signed [ACC_W-1:0] beat_ext;
    logic signed [ACC_W-1:0] sum_next;

    logic                    post_vld;
    logic signed [ACC_W-1:0] post_sum;
    logic signed [ACC_W:0]   sum_wide;
    logic signed [ACC_W:0]   half;
    logic signed [ACC_W:0]   rounded;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [OUT_W-1:0]        result;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [OUT_W-1:0]        fifo_head;
    logic                    drop;

    assign beat_ext = {{(ACC_W-MAC_W){accu_bus.mac_out_data[MAC_W-1]}}, accu_bus.mac_out_data};
    assign sum_next = partial + beat_ext;

    // Control FSM with beat counter and partial sum; the closing beat hands its sum to the post stage.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            trunc_q  <= '0;
            beat_cnt <= '0;
            partial  <= '0;
            post_vld <= 1'b0;
            post_sum <= '0;
        end else begin
            post_vld <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_reg_en) begin
                        state    <= ST_RUN;
                        len_q    <= cfg_accu_len;
                        trunc_q  <= cfg_trunc;
                        beat_cnt <= '0;
                        partial  <= '0;
                    end
                end
                ST_RUN: begin
                    if (cfg_reg_en) begin
                        len_q    <= cfg_accu_len;
                        trunc_q  <= cfg_trunc;
                        beat_cnt <= '0;
                        partial  <= '0;
                    end else if (accu_bus.mac_out_pvld) begin
                        if (beat_cnt == len_q) begin
                            post_vld <= 1'b1;
                            post_sum <= sum_next;
                            partial  <= '0;
                            beat_cnt <= '0;
                        end else begin
                            partial  <= sum_next;
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Round-half-up shift at one extra bit of headroom, then clamp into the 32-bit output range.
    always_comb begin
        sum_wide = {post_sum[ACC_W-1], post_sum};
        half     = '0;
        if (trunc_q != 5'd0) begin
            half = (ACC_W+1)'(1) << (trunc_q - 5'd1);
        end
        rounded = (sum_wide + half) >>> trunc_q;
        sat_hi  = (rounded > SAT_MAX_R);
        sat_lo  = (rounded < SAT_MIN_R);
        if (sat_hi) begin
            result = SAT_MAX_OUT;
        end else if (sat_lo) begin
            result = SAT_MIN_OUT;
        end else begin
            result = rounded[OUT_W-1:0];
        end
    end

    // A write is lost only when the FIFO is full and nothing is being read out this cycle.
    assign drop = post_vld && fifo_full && !accu_bus.accu_out_prdy;

    // Status flags: sticky overflow and saturating clamp counter, both cleared by reconfiguration.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            accu_ovf     <= 1'b0;
            accu_sat_cnt <= '0;
        end else if (cfg_reg_en) begin
            accu_ovf     <= 1'b0;
            accu_sat_cnt <= '0;
        end else begin
            if (drop) begin
                accu_ovf <= 1'b1;
            end
            if (post_vld && (sat_hi || sat_lo) && (accu_sat_cnt != 16'hFFFF)) begin
                accu_sat_cnt <= accu_sat_cnt + 16'd1;
            end
        end
    end

    mac_accu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .wr_en           (post_vld),
        .wr_data         (result),
        .rd_en           (accu_bus.accu_out_prdy),
        .rd_data         (fifo_head),
        .full            (fifo_full),
        .empty           (fifo_empty)
    );

    assign accu_bus.accu_out_data = fifo_head;
    assign accu_bus.accu_out_pvld = !fifo_empty;

endmodule

// File: tb/tb_mac_accu.sv
// Directed bench for mac_accu: a table of single-beat rounding/saturation vectors plus
// hand-written sequences for accumulation, throughput, overflow, reconfig and async reset.
module tb_mac_accu;

    logic        nvdla_core_clk;
    logic        nvdla_core_rstn;
    logic        cfg_reg_en;
    logic [7:0]  cfg_accu_len;
    logic [4:0]  cfg_trunc;
    logic        accu_ovf;
    logic [15:0] accu_sat_cnt;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [4:0]  trunc;
        logic [35:0] data;
        logic [31:0] exp_data;
        logic [15:0] exp_sat;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    mac_accu_if bus ();

    mac_accu dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .cfg_reg_en      (cfg_reg_en),
        .cfg_accu_len    (cfg_accu_len),
        .cfg_trunc       (cfg_trunc),
        .accu_bus        (bus.master),
        .accu_ovf        (accu_ovf),
        .accu_sat_cnt    (accu_sat_cnt)
    );

    initial nvdla_core_clk = 1'b0;
    always #5 nvdla_core_clk = ~nvdla_core_clk;

    // Drive one cycle of inputs at the falling edge and return at the next falling edge.
    task automatic applyStimulus(input logic cfg, input logic [7:0] len, input logic [4:0] trunc,
                                 input logic pvld, input logic [35:0] data);
        cfg_reg_en       = cfg;
        cfg_accu_len     = len;
        cfg_trunc        = trunc;
        bus.mac_out_pvld = pvld;
        bus.mac_out_data = data;
        @(posedge nvdla_core_clk);
        @(negedge nvdla_core_clk);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        vecs[0]  = '{5'd0,  36'h0_0000_0064, 32'h0000_0064, 16'd0};
        vecs[1]  = '{5'd4,  36'h0_0000_0018, 32'h0000_0002, 16'd0};
        vecs[2]  = '{5'd4,  36'hF_FFFF_FFE8, 32'hFFFF_FFFF, 16'd0};
        vecs[3]  = '{5'd1,  36'hF_FFFF_FFFD, 32'hFFFF_FFFF, 16'd0};
        vecs[4]  = '{5'd1,  36'h0_0000_0003, 32'h0000_0002, 16'd0};
        vecs[5]  = '{5'd0,  36'h7_FFFF_FFFF, 32'h7FFF_FFFF, 16'd1};
        vecs[6]  = '{5'd0,  36'h8_0000_0000, 32'h8000_0000, 16'd1};
        vecs[7]  = '{5'd4,  36'h7_FFFF_FFFF, 32'h7FFF_FFFF, 16'd1};
        vecs[8]  = '{5'd4,  36'h7_FFFF_FFEF, 32'h7FFF_FFFF, 16'd0};
        vecs[9]  = '{5'd31, 36'h7_FFFF_FFFF, 32'h0000_0010, 16'd0};
        vecs[10] = '{5'd31, 36'hF_C000_0000, 32'h0000_0000, 16'd0};
        vecs[11] = '{5'd31, 36'hF_BFFF_FFFF, 32'hFFFF_FFFF, 16'd0};
        vecs[12] = '{5'd0,  36'hF_8000_0000, 32'h8000_0000, 16'd0};
        vecs[13] = '{5'd0,  36'hF_7FFF_FFFF, 32'h8000_0000, 16'd1};

        nvdla_core_rstn   = 1'b0;
        cfg_reg_en        = 1'b0;
        cfg_accu_len      = '0;
        cfg_trunc         = '0;
        bus.mac_out_pvld  = 1'b0;
        bus.mac_out_data  = '0;
        bus.accu_out_prdy = 1'b1;
        repeat (2) @(negedge nvdla_core_clk);

        checkOutput("reset_pvld", 64'(bus.accu_out_pvld), 64'd0);
        checkOutput("reset_data", 64'(bus.accu_out_data), 64'd0);
        checkOutput("reset_ovf",  64'(accu_ovf), 64'd0);
        checkOutput("reset_sat",  64'(accu_sat_cnt), 64'd0);
        nvdla_core_rstn = 1'b1;
        @(negedge nvdla_core_clk);

        // Beats before any configuration are ignored.
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b1, 36'd55);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b0, 36'd0);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b0, 36'd0);
        checkOutput("idle_ignore_pvld", 64'(bus.accu_out_pvld), 64'd0);

        // Single-beat rounding and saturation table.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(1'b1, 8'd0, vecs[i].trunc, 1'b0, 36'd0);
            applyStimulus(1'b0, 8'd0, vecs[i].trunc, 1'b1, vecs[i].data);
            applyStimulus(1'b0, 8'd0, vecs[i].trunc, 1'b0, 36'd0);
            checkOutput($sformatf("vec%0d_pvld", i), 64'(bus.accu_out_pvld), 64'd1);
            checkOutput($sformatf("vec%0d_data", i), 64'(bus.accu_out_data), 64'(vecs[i].exp_data));
            checkOutput($sformatf("vec%0d_sat", i),  64'(accu_sat_cnt), 64'(vecs[i].exp_sat));
            applyStimulus(1'b0, 8'd0, vecs[i].trunc, 1'b0, 36'd0);
            checkOutput($sformatf("vec%0d_drained", i), 64'(bus.accu_out_pvld), 64'd0);
        end

        // Four-beat point; result appears two cycles after the last beat.
        applyStimulus(1'b1, 8'd3, 5'd0, 1'b0, 36'd0);
        applyStimulus(1'b0, 8'd3, 5'd0, 1'b1, 36'd100);
        applyStimulus(1'b0, 8'd3, 5'd0, 1'b1, 36'hF_FFFF_FFEC);
        applyStimulus(1'b0, 8'd3, 5'd0, 1'b1, 36'd5);
        applyStimulus(1'b0, 8'd3, 5'd0, 1'b1, 36'd15);
        checkOutput("basic_k1_pvld", 64'(bus.accu_out_pvld), 64'd0);
        applyStimulus(1'b0, 8'd3, 5'd0, 1'b0, 36'd0);
        checkOutput("basic_pvld", 64'(bus.accu_out_pvld), 64'd1);
        checkOutput("basic_data", 64'(bus.accu_out_data), 64'd100);
        applyStimulus(1'b0, 8'd3, 5'd0, 1'b0, 36'd0);
        checkOutput("basic_drained", 64'(bus.accu_out_pvld), 64'd0);

        // Two-beat points that clamp high then low; counter accumulates across points.
        applyStimulus(1'b1, 8'd1, 5'd0, 1'b0, 36'd0);
        applyStimulus(1'b0, 8'd1, 5'd0, 1'b1, 36'h7_FFFF_FFFF);
        applyStimulus(1'b0, 8'd1, 5'd0, 1'b1, 36'h7_FFFF_FFFF);
        applyStimulus(1'b0, 8'd1, 5'd0, 1'b1, 36'h8_0000_0000);
        checkOutput("sat_pos_data", 64'(bus.accu_out_data), 64'h7FFF_FFFF);
        checkOutput("sat_pos_cnt",  64'(accu_sat_cnt), 64'd1);
        applyStimulus(1'b0, 8'd1, 5'd0, 1'b1, 36'h8_0000_0000);
        applyStimulus(1'b0, 8'd1, 5'd0, 1'b0, 36'd0);
        checkOutput("sat_neg_data", 64'(bus.accu_out_data), 64'h8000_0000);
        checkOutput("sat_neg_cnt",  64'(accu_sat_cnt), 64'd2);
        applyStimulus(1'b0, 8'd1, 5'd0, 1'b0, 36'd0);

        // Back-to-back single-beat points drain one per cycle.
        applyStimulus(1'b1, 8'd0, 5'd0, 1'b0, 36'd0);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b1, 36'd11);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b1, 36'd12);
        checkOutput("thru_0", 64'(bus.accu_out_data), 64'd11);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b1, 36'd13);
        checkOutput("thru_1", 64'(bus.accu_out_data), 64'd12);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b0, 36'd0);
        checkOutput("thru_2", 64'(bus.accu_out_data), 64'd13);
        checkOutput("thru_2_pvld", 64'(bus.accu_out_pvld), 64'd1);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b0, 36'd0);
        checkOutput("thru_drained", 64'(bus.accu_out_pvld), 64'd0);

        // Overflow with downstream stalled: first four kept, 5 and 6 dropped.
        bus.accu_out_prdy = 1'b0;
        applyStimulus(1'b1, 8'd0, 5'd0, 1'b0, 36'd0);
        for (int v = 1; v <= 6; v++) begin
            applyStimulus(1'b0, 8'd0, 5'd0, 1'b1, 36'(v));
            if (v == 5) checkOutput("ovf_before_drop", 64'(accu_ovf), 64'd0);
            if (v == 6) checkOutput("ovf_after_drop", 64'(accu_ovf), 64'd1);
        end
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b0, 36'd0);
        checkOutput("ovf_head", 64'(bus.accu_out_data), 64'd1);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b0, 36'd0);
        checkOutput("ovf_head_stable", 64'(bus.accu_out_data), 64'd1);
        checkOutput("ovf_sticky", 64'(accu_ovf), 64'd1);
        bus.accu_out_prdy = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            checkOutput($sformatf("drain%0d_pvld", v), 64'(bus.accu_out_pvld), 64'd1);
            checkOutput($sformatf("drain%0d_data", v), 64'(bus.accu_out_data), 64'(v));
            applyStimulus(1'b0, 8'd0, 5'd0, 1'b0, 36'd0);
        end
        checkOutput("drain_empty", 64'(bus.accu_out_pvld), 64'd0);

        // Reconfig mid-point discards the partial sum and the coincident beat.
        applyStimulus(1'b1, 8'd3, 5'd0, 1'b0, 36'd0);
        applyStimulus(1'b0, 8'd3, 5'd0, 1'b1, 36'd10);
        applyStimulus(1'b0, 8'd3, 5'd0, 1'b1, 36'd10);
        applyStimulus(1'b1, 8'd0, 5'd0, 1'b1, 36'd7);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b1, 36'd9);
        checkOutput("recfg_no_out", 64'(bus.accu_out_pvld), 64'd0);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b0, 36'd0);
        checkOutput("recfg_pvld", 64'(bus.accu_out_pvld), 64'd1);
        checkOutput("recfg_data", 64'(bus.accu_out_data), 64'd9);
        checkOutput("recfg_ovf",  64'(accu_ovf), 64'd0);
        checkOutput("recfg_sat",  64'(accu_sat_cnt), 64'd0);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b0, 36'd0);
        checkOutput("recfg_drained", 64'(bus.accu_out_pvld), 64'd0);

        // Async reset with results pending clears everything at once and returns to IDLE.
        bus.accu_out_prdy = 1'b0;
        applyStimulus(1'b1, 8'd0, 5'd0, 1'b0, 36'd0);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b1, 36'd5);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b1, 36'h7_FFFF_FFFF);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b0, 36'd0);
        checkOutput("prerst_pvld", 64'(bus.accu_out_pvld), 64'd1);
        checkOutput("prerst_sat",  64'(accu_sat_cnt), 64'd1);
        nvdla_core_rstn = 1'b0;
        #1;
        checkOutput("rst_pvld", 64'(bus.accu_out_pvld), 64'd0);
        checkOutput("rst_data", 64'(bus.accu_out_data), 64'd0);
        checkOutput("rst_sat",  64'(accu_sat_cnt), 64'd0);
        checkOutput("rst_ovf",  64'(accu_ovf), 64'd0);
        @(negedge nvdla_core_clk);
        nvdla_core_rstn   = 1'b1;
        bus.accu_out_prdy = 1'b1;
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b1, 36'd3);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b1, 36'd3);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b0, 36'd0);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b0, 36'd0);
        checkOutput("postrst_idle", 64'(bus.accu_out_pvld), 64'd0);
        applyStimulus(1'b1, 8'd0, 5'd0, 1'b0, 36'd0);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b1, 36'd4);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b0, 36'd0);
        checkOutput("postrst_data", 64'(bus.accu_out_data), 64'd4);
        applyStimulus(1'b0, 8'd0, 5'd0, 1'b0, 36'd0);
        checkOutput("postrst_drained", 64'(bus.accu_out_pvld), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mac_accu.md
# mac_accu

Accumulation stage directly downstream of the INT16 MAC unit. Consumes the 36-bit signed per-cycle dot-product (`mac_out_data` / `mac_out_pvld`) and sums a configured number of consecutive beats into one output point. Each point is rounded and right-shifted, then saturated to 32 bits, and buffered in a small FIFO behind a valid/ready handshake. The MAC has no backpressure, so the FIFO absorbs output stalls, and overflow is flagged rather than stalling the MAC.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2).
- `ACC_W`, 44: accumulator width (36 + 8 guard bits for 256 beats).

Ports:
- `nvdla_core_clk`  in  1  sole clock.
- `nvdla_core_rstn`  in  1  asynchronous, active-low reset.
- `cfg_reg_en`  in  1  one-cycle pulse; latches config, clears the partial sum, counters and flags.
- `cfg_accu_len`  in  8  beats per point minus 1 (0→1 beat, 255→256 beats).
- `cfg_trunc`  in  5  arithmetic right shift with round-half-up, 0..31.
- `mac_out_data`  in  36  signed partial sum from the MAC.
- `mac_out_pvld`  in  1  beat valid; there is no ready, and every valid beat is consumed.
- `accu_out_data`  out  32  saturated result.
- `accu_out_pvld`  out  1  FIFO non-empty.
- `accu_out_prdy`  in  1  downstream ready.
- `accu_ovf`  out  1  sticky: a result was dropped because the FIFO was full.
- `accu_sat_cnt`  out  16  saturation events, saturating at 0xFFFF.

## Operation
- FSM: IDLE → RUN on `cfg_reg_en`. RUN stays in RUN; `cfg_reg_en` in RUN reloads config.
- IDLE: beats are ignored.
- Reset clears all state to IDLE. All outputs are 0 in reset, and the FIFO is empty.
- RUN datapath:
  - Each valid beat is sign-extended to ACC_W and added to the partial sum.
  - The beat counter increments on each beat.
  - On beat index == `cfg_accu_len`, the final sum (partial + beat) is registered into the post stage. The partial sum and counter then clear.
  - Back-to-back points need no bubble.
- Post stage:
  - Rounding: r = (sum + (trunc ? 1<<(trunc-1) : 0)) >>> trunc. Computed at ACC_W+1 bits so that no intermediate wrap occurs.
  - Saturation: r is clamped to [−2^31, 2^31−1]. Each clamp increments `accu_sat_cnt`.
- FIFO write:
  - The post-stage result is written next cycle if the FIFO is not full.
  - If the FIFO is full, the result is dropped and `accu_ovf` is set.
  - A write and a read in the same cycle on a full FIFO succeed, and the result is not dropped.
- `cfg_reg_en` simultaneous with `mac_out_pvld`: config wins and the beat is discarded.
- `cfg_reg_en` mid-point: the partial sum is discarded. An in-flight post-stage result still completes into the FIFO. FIFO contents are preserved.
- `cfg_reg_en` clears `accu_ovf` and `accu_sat_cnt`.

## Timing
- Latency: final beat in cycle k → `accu_out_pvld` high in cycle k+2 (FIFO empty, ready irrelevant).
- Throughput: 1 point/cycle sustained when `cfg_accu_len`=0 and `accu_out_prdy`=1.
- Handshake:
  - Transfer occurs when `accu_out_pvld` & `accu_out_prdy`.
  - `accu_out_data` is stable while valid and not ready. It is the FIFO head, driven from a register or read-mux with no combinational path from inputs.
- `accu_ovf` asserts the cycle after the dropped write would have occurred.
- `accu_sat_cnt` updates in the same cycle as the corresponding FIFO write attempt. It counts even if that write is dropped.

## Structure
- Shared package `mac_accu_pkg` holds:
  - ACC_W, OUT_W=32, MAC_W=36;
  - the FSM state encoding (IDLE, RUN);
  - the saturation bounds.
- Sub-module `mac_accu_fifo`: a synchronous FIFO_DEPTH-entry FIFO with full/empty and async active-low reset.
- The top contains the FSM, counter, accumulator and round/sat stage.

## Test plan
- **Basic:** `cfg_accu_len`=3, trunc=0; beats 100, −20, 5, 15 in consecutive cycles → one output 100, valid 2 cycles after beat 4.
- **Round/shift:** len=0, trunc=4; beat 24 → 2 (24/16 = 1.5 rounds up); beat −24 → −1.
- **Saturation:** len=1, trunc=0; beats 0x7_FFFF_FFFF, 0x7_FFFF_FFFF → 0x7FFFFFFF and `accu_sat_cnt`=1. Beats −2^35 twice → 0x80000000 and count=2.
- **Backpressure/overflow:** len=0; `accu_out_prdy`=0; 6 beats of values 1..6 → FIFO holds 1..4 and `accu_ovf`=1. Releasing ready drains 1,2,3,4 in order.
- **Reconfig mid-point:** len=3; 2 beats of 10, then `cfg_reg_en` with len=0 together with a beat of 7 → the 7 is discarded, no output. A next beat of 9 → output 9, and `accu_ovf`/`sat_cnt` read 0.
- **Async reset mid-operation:** assert rstn low during a point with a FIFO entry pending → all outputs 0 immediately and state IDLE. Beats are ignored until `cfg_reg_en`.
